// File: rtl/ps2_scancode_fifo_pkg.sv
// Shared definitions for the PS/2 scan-code event path: prefix byte values,
// prefix-decoder states and the packed event record stored in the FIFO.
package ps2_scancode_fifo_pkg;

  // Protocol bytes seen on the PS/2 receive side
  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;

  // Prefix decoder states
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } ps2_state_t;

  // One folded key event as held in the FIFO
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

  localparam int unsigned EVT_W = $bits(ps2_evt_t);

  // True for bytes that only modify the next code
  function automatic logic is_prefix(input logic [7:0] b);
    return (b == PS2_EXT) || (b == PS2_BRK);
  endfunction

  // True for keyboard status bytes that carry no key information
  function automatic logic is_status(input logic [7:0] b);
    return (b == PS2_BAT_OK) || (b == PS2_ACK);
  endfunction

endpackage

// File: rtl/ps2_scancode_fifo_sync_fifo.sv
// First-word-fall-through synchronous FIFO: the head entry is always visible
// on rd_data while the FIFO is non-empty. A write while full is accepted only
// when a read frees a slot in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = rd_en && !empty;
  assign do_push = wr_en && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  // Storage write; contents need no reset because count gates visibility
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap at the power-of-two depth
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_scancode_fifo.sv
// PS/2 scan-code front end: folds E0/F0 prefixes into single key events,
// queues them for the processor, keeps a short history of make codes and
// flags any event lost to a full queue.
module ps2_scancode_fifo
  import ps2_scancode_fifo_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned HISTORY   = 4,
  parameter int unsigned TIMEOUT   = 50000,
  parameter bit          MAKE_ONLY = 1'b0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        ps2_key_pressed,
  input  logic [7:0]                  ps2_key_data,
  input  logic                        evt_ready,
  output logic                        evt_valid,
  output logic [7:0]                  evt_code,
  output logic                        evt_ext,
  output logic                        evt_brk,
  output logic [$clog2(DEPTH+1)-1:0]  evt_count,
  output logic                        overflow,
  input  logic                        overflow_clr,
  output logic [8*HISTORY-1:0]        hist_codes
);

  localparam int unsigned HW = 8 * HISTORY;
  localparam int unsigned TW = $clog2(TIMEOUT);

  ps2_state_t    state;
  logic [TW-1:0] tmo_cnt;

  logic          emit;
  ps2_evt_t      emit_evt;
  logic          push;
  logic          pop;
  logic          drop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [EVT_W-1:0] head_raw;
  ps2_evt_t      head;

  // Decode the incoming byte against the current prefix state
  always_comb begin
    emit          = 1'b0;
    emit_evt      = '0;
    emit_evt.code = ps2_key_data;
    emit_evt.ext  = (state == ST_EXT) || (state == ST_EXT_BRK);
    emit_evt.brk  = (state == ST_BRK) || (state == ST_EXT_BRK);
    if (ps2_key_pressed && !is_prefix(ps2_key_data)) begin
      // Status bytes are only meaningful outside a prefix sequence
      emit = !((state == ST_IDLE) && is_status(ps2_key_data));
    end
  end

  // Prefix FSM with timeout; a strobe always wins over an expiring counter
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      tmo_cnt <= '0;
    end else if (ps2_key_pressed) begin
      tmo_cnt <= '0;
      case (state)
        ST_IDLE: begin
          if (ps2_key_data == PS2_EXT)      state <= ST_EXT;
          else if (ps2_key_data == PS2_BRK) state <= ST_BRK;
          else                              state <= ST_IDLE;
        end
        ST_EXT: begin
          if (ps2_key_data == PS2_BRK)      state <= ST_EXT_BRK;
          else if (ps2_key_data == PS2_EXT) state <= ST_EXT;
          else                              state <= ST_IDLE;
        end
        ST_BRK: begin
          if (ps2_key_data == PS2_EXT)      state <= ST_EXT_BRK;
          else if (ps2_key_data == PS2_BRK) state <= ST_BRK;
          else                              state <= ST_IDLE;
        end
        ST_EXT_BRK: begin
          if (is_prefix(ps2_key_data))      state <= ST_EXT_BRK;
          else                              state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end else if (state != ST_IDLE) begin
      if (tmo_cnt == TW'(TIMEOUT - 1)) begin
        state   <= ST_IDLE;
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end
    end else begin
      tmo_cnt <= '0;
    end
  end

  assign push = emit && !(emit_evt.brk && MAKE_ONLY);
  assign pop  = evt_valid && evt_ready;
  assign drop = push && fifo_full && !pop;

  sync_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (push),
    .wr_data (emit_evt),
    .rd_en   (evt_ready),
    .rd_data (head_raw),
    .count   (evt_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign head      = ps2_evt_t'(head_raw);
  assign evt_valid = !fifo_empty;
  assign evt_code  = head.code;
  assign evt_ext   = head.ext;
  assign evt_brk   = head.brk;

  // Sticky overflow; a drop in the same cycle outranks a clear request
  always_ff @(posedge clock) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

  // Make-code history, newest in the low byte; independent of queue space
  always_ff @(posedge clock) begin
    if (reset) begin
      hist_codes <= '0;
    end else if (emit && !emit_evt.brk) begin
      hist_codes <= (hist_codes << 8) | HW'(emit_evt.code);
    end
  end

endmodule

// File: tb/tb_ps2_scancode_fifo.sv
// Bench for ps2_scancode_fifo: two instances (normal and make-only) run the
// same directed byte stream against a queue-based reference model.
module tb_ps2_scancode_fifo;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned HISTORY = 3;
  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned CW      = $clog2(DEPTH + 1);
  localparam int unsigned HW      = 8 * HISTORY;

  logic          clock;
  logic          reset;
  logic          ps2_key_pressed;
  logic [7:0]    ps2_key_data;
  logic          evt_ready;
  logic          overflow_clr;

  logic          v0, x0, b0, o0;
  logic [7:0]    c0;
  logic [CW-1:0] n0;
  logic [HW-1:0] h0;
  logic          v1, x1, b1, o1;
  logic [7:0]    c1;
  logic [CW-1:0] n1;
  logic [HW-1:0] h1;

  int n_pass  = 0;
  int n_total = 0;
  bit armed   = 0;

  ps2_scancode_fifo #(
    .DEPTH(DEPTH), .HISTORY(HISTORY), .TIMEOUT(TIMEOUT), .MAKE_ONLY(1'b0)
  ) u_dut (
    .clock(clock), .reset(reset), .ps2_key_pressed(ps2_key_pressed),
    .ps2_key_data(ps2_key_data), .evt_ready(evt_ready), .evt_valid(v0),
    .evt_code(c0), .evt_ext(x0), .evt_brk(b0), .evt_count(n0),
    .overflow(o0), .overflow_clr(overflow_clr), .hist_codes(h0)
  );

  ps2_scancode_fifo #(
    .DEPTH(DEPTH), .HISTORY(HISTORY), .TIMEOUT(TIMEOUT), .MAKE_ONLY(1'b1)
  ) u_dut_mo (
    .clock(clock), .reset(reset), .ps2_key_pressed(ps2_key_pressed),
    .ps2_key_data(ps2_key_data), .evt_ready(evt_ready), .evt_valid(v1),
    .evt_code(c1), .evt_ext(x1), .evt_brk(b1), .evt_count(n1),
    .overflow(o1), .overflow_clr(overflow_clr), .hist_codes(h1)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  // Events are {ext, brk, code}; index 0 = normal instance, 1 = make-only.
  logic [9:0]    m_q [2][DEPTH];
  int            m_size [2];
  logic          m_ovf [2];
  logic [HW-1:0] m_hist;
  logic          m_pend, m_ext, m_brk;
  int            m_age;

  initial begin
    logic [9:0] ev;
    bit         emit, dropped;
    forever begin
      @(posedge clock);
      if (reset) begin
        for (int d = 0; d < 2; d++) begin
          m_size[d] = 0;
          m_ovf[d]  = 1'b0;
        end
        m_hist = '0;
        m_pend = 0; m_ext = 0; m_brk = 0; m_age = 0;
        armed  = 1;
      end else begin
        for (int d = 0; d < 2; d++) begin
          if (m_size[d] > 0 && evt_ready) begin
            for (int i = 1; i < m_size[d]; i++) m_q[d][i-1] = m_q[d][i];
            m_size[d]--;
          end
        end
        emit = 0;
        ev   = '0;
        if (ps2_key_pressed) begin
          m_age = 0;
          if (ps2_key_data == 8'hE0) begin
            m_pend = 1; m_ext = 1;
          end else if (ps2_key_data == 8'hF0) begin
            m_pend = 1; m_brk = 1;
          end else if (!m_pend && (ps2_key_data == 8'hAA || ps2_key_data == 8'hFA)) begin
            emit = 0;
          end else begin
            emit = 1;
            ev   = {m_ext, m_brk, ps2_key_data};
            m_pend = 0; m_ext = 0; m_brk = 0;
          end
        end else if (m_pend) begin
          m_age++;
          if (m_age >= int'(TIMEOUT)) begin
            m_pend = 0; m_ext = 0; m_brk = 0; m_age = 0;
          end
        end
        if (emit && !ev[8]) m_hist = (m_hist << 8) | HW'(ev[7:0]);
        for (int d = 0; d < 2; d++) begin
          dropped = 0;
          if (emit && !(ev[8] && d == 1)) begin
            if (m_size[d] < int'(DEPTH)) begin
              m_q[d][m_size[d]] = ev;
              m_size[d]++;
            end else begin
              dropped = 1;
            end
          end
          if (dropped)           m_ovf[d] = 1'b1;
          else if (overflow_clr) m_ovf[d] = 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus a log of popped events
  logic [9:0] log0[$];
  logic [9:0] log1[$];

  always @(negedge clock) begin
    if (armed) begin
      chk("u0_valid", 32'(v0), 32'(m_size[0] != 0));
      chk("u0_count", 32'(n0), 32'(m_size[0]));
      chk("u0_ovf",   32'(o0), 32'(m_ovf[0]));
      chk("u0_hist",  32'(h0), 32'(m_hist));
      if (m_size[0] != 0) chk("u0_head", 32'({x0, b0, c0}), 32'(m_q[0][0]));
      chk("u1_valid", 32'(v1), 32'(m_size[1] != 0));
      chk("u1_count", 32'(n1), 32'(m_size[1]));
      chk("u1_ovf",   32'(o1), 32'(m_ovf[1]));
      chk("u1_hist",  32'(h1), 32'(m_hist));
      if (m_size[1] != 0) chk("u1_head", 32'({x1, b1, c1}), 32'(m_q[1][0]));
      if (!reset && evt_ready && v0) log0.push_back({x0, b0, c0});
      if (!reset && evt_ready && v1) log1.push_back({x1, b1, c1});
    end
  end

  // ---------------- stimulus ----------------
  logic [9:0] exp_q[$];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [7:0] b);
    ps2_key_pressed = 1'b1;
    ps2_key_data    = b;
    tick();
    ps2_key_pressed = 1'b0;
    ps2_key_data    = 8'h00;
  endtask

  task automatic clear_logs();
    log0.delete();
    log1.delete();
  endtask

  task automatic check_log(input string nm, input bit sel);
    logic [9:0] got[$];
    int         n;
    got = sel ? log1 : log0;
    chk($sformatf("%s_len", nm), 32'(got.size()), 32'(exp_q.size()));
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_%0d", nm, i), 32'(got[i]), 32'(exp_q[i]));
  endtask

  initial begin
    reset           = 1'b1;
    ps2_key_pressed = 1'b0;
    ps2_key_data    = 8'h00;
    evt_ready       = 1'b0;
    overflow_clr    = 1'b0;
    idle(2);
    reset = 1'b0;
    chk("rst_valid", 32'(v0), 32'(0));
    chk("rst_count", 32'(n0), 32'(0));
    chk("rst_ovf",   32'(o0), 32'(0));
    chk("rst_hist",  32'(h0), 32'(0));

    // 1) make then break of the same key
    evt_ready = 1'b1;
    clear_logs();
    send(8'h1C); send(8'hF0); send(8'h1C);
    idle(3);
    exp_q = '{10'h01C, 10'h11C};
    check_log("t1_evts", 0);
    exp_q = '{10'h01C};
    check_log("t1_mo_evts", 1);
    chk("t1_hist", 32'(h0), 32'h00001C);
    chk("t1_count", 32'(n0), 32'(0));

    // 2) extended make / extended break; status bytes vanish
    clear_logs();
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hAA); send(8'hFA);
    idle(3);
    exp_q = '{10'h275, 10'h375};
    check_log("t2_evts", 0);
    chk("t2_hist", 32'(h0), 32'h001C75);

    // 3) overfill by two, drain, clear overflow
    evt_ready = 1'b0;
    clear_logs();
    for (int i = 0; i < int'(DEPTH) + 2; i++) send(8'(8'h10 + i));
    idle(1);
    chk("t3_count", 32'(n0), 32'(DEPTH));
    chk("t3_ovf", 32'(o0), 32'(1));
    chk("t3_hist", 32'(h0), 32'h131415);
    evt_ready = 1'b1;
    idle(int'(DEPTH) + 2);
    evt_ready = 1'b0;
    exp_q = '{10'h010, 10'h011, 10'h012, 10'h013};
    check_log("t3_evts", 0);
    chk("t3_ovf_held", 32'(o0), 32'(1));
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    chk("t3_ovf_clr", 32'(o0), 32'(0));

    // 4) push and pop together while full
    clear_logs();
    for (int i = 0; i < int'(DEPTH); i++) send(8'(8'h20 + i));
    evt_ready = 1'b1;
    send(8'h24);
    evt_ready = 1'b0;
    idle(1);
    chk("t4_count", 32'(n0), 32'(DEPTH));
    chk("t4_ovf", 32'(o0), 32'(0));
    evt_ready = 1'b1;
    idle(int'(DEPTH) + 2);
    exp_q = '{10'h020, 10'h021, 10'h022, 10'h023, 10'h024};
    check_log("t4_evts", 0);

    // 5) prefix timeout: expired after TIMEOUT idle cycles, alive one cycle earlier
    clear_logs();
    send(8'hE0); idle(int'(TIMEOUT)); send(8'h1C);
    idle(2);
    send(8'hE0); idle(int'(TIMEOUT) - 1); send(8'h1C);
    idle(3);
    exp_q = '{10'h01C, 10'h21C};
    check_log("t5_evts", 0);

    // 6) reset in the middle of a break sequence with entries queued
    evt_ready = 1'b0;
    send(8'h30); send(8'h31); send(8'h32); send(8'hF0);
    chk("t6_pre_count", 32'(n0), 32'(3));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_valid", 32'(v0), 32'(0));
    chk("t6_count", 32'(n0), 32'(0));
    clear_logs();
    evt_ready = 1'b1;
    send(8'h1C);
    idle(3);
    exp_q = '{10'h01C};
    check_log("t6_evts", 0);
    check_log("t6_mo_evts", 1);
    chk("t6_hist", 32'(h0), 32'h00001C);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
